// File: rtl/data_mem_resp_if.sv
// Request/acknowledge bus between a CPU-side requester and the data memory responder.
interface data_mem_resp_if;
  logic        in_data_mem;   // level request, held until acknowledged
  logic        write_data;    // 1 = write, 0 = read
  logic [3:0]  adr;
  logic [15:0] data_write;
  logic [15:0] data;          // registered read data
  logic        out_data_mem;  // one-cycle acknowledge
  logic        busy;

  modport master (
    output in_data_mem,
    output write_data,
    output adr,
    output data_write,
    input  data,
    input  out_data_mem,
    input  busy
  );

  modport slave (
    input  in_data_mem,
    input  write_data,
    input  adr,
    input  data_write,
    output data,
    output out_data_mem,
    output busy
  );
endinterface

// File: rtl/data_mem_resp.sv
// 16x16 data memory with a fixed-latency request/acknowledge handshake.
// A request is captured in IDLE, waits WAIT_CYCLES busy cycles, performs its
// access on the edge entering ACK, pulses the acknowledge for one cycle, then
// parks in RELEASE until the requester drops its level request.
module data_mem_resp #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_resp_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StBusy, StAck, StRelease} state_e;

  // Counter preload; a zero wait goes straight to ACK so the counter is unused.
  localparam logic [3:0] CntLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  adr_q, adr_d;
  logic        wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;
  logic [15:0] mem_q [16];
  logic        enter_ack;
  logic        mem_we;

  // State register plus captured request fields and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      adr_q   <= 4'd0;
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Next-state, wait counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_data_mem) begin
          adr_d   = bus_io.adr;
          wr_d    = bus_io.write_data;
          wdata_d = bus_io.data_write;
          cnt_d   = CntLoad;
          state_d = (WAIT_CYCLES == 0) ? StAck : StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StRelease;
      end
      StRelease: begin
        // Wait for the level request to drop so it is not serviced twice.
        if (!bus_io.in_data_mem) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory access happens on the edge entering ACK. The _d copies of the
  // captured fields are used so a zero-wait request is served from the
  // values being captured on that same edge.
  always_comb begin
    enter_ack = (state_d == StAck) && (state_q != StAck);
    mem_we    = enter_ack && wr_d;
    data_d    = data_q;
    if (enter_ack && !wr_d) begin
      data_d = mem_q[adr_d];
    end
  end

  // Storage array; cleared by reset so an abandoned write never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (mem_we) begin
      mem_q[adr_d] <= wdata_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus_io.out_data_mem = (state_q == StAck);
    bus_io.busy         = (state_q != StIdle);
    bus_io.data         = data_q;
  end

  // The acknowledge never lasts more than one cycle.
  ack_single_cycle: assert property (
    @(posedge clk) disable iff (!rst_n) bus_io.out_data_mem |=> !bus_io.out_data_mem
  );

  // The acknowledge always implies busy.
  ack_implies_busy: assert property (
    @(posedge clk) disable iff (!rst_n) bus_io.out_data_mem |-> bus_io.busy
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// Drives the same transaction stream into a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance; a reference memory predicts read data and acknowledge timing, and
// per-instance monitors pop and compare expectations on every acknowledge.
module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req;
  logic        wr;
  logic [3:0]  adr;
  logic [15:0] wdata;

  data_mem_resp_if bus_a ();
  data_mem_resp_if bus_b ();

  assign bus_a.in_data_mem = req;
  assign bus_a.write_data  = wr;
  assign bus_a.adr         = adr;
  assign bus_a.data_write  = wdata;
  assign bus_b.in_data_mem = req;
  assign bus_b.write_data  = wr;
  assign bus_b.adr         = adr;
  assign bus_b.data_write  = wdata;

  data_mem_resp #(.WAIT_CYCLES(2)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_a.slave)
  );

  data_mem_resp #(.WAIT_CYCLES(0)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_b.slave)
  );

  typedef struct {
    logic [15:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acks_a = 0;
  int acks_b = 0;

  logic [15:0] ref_mem [16];
  logic [15:0] ref_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Move to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor for the WAIT_CYCLES=2 instance.
  always @(negedge clk) begin
    if (rst_n && bus_a.out_data_mem) begin
      acks_a++;
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack_a: ack at cycle %0d, none expected", cyc);
      end else begin
        ea = q_a.pop_front();
        chk("ack_cycle_a", cyc, ea.ack_cyc);
        chk("rdata_a", {16'h0, bus_a.data}, {16'h0, ea.data});
      end
    end
  end

  // Monitor for the WAIT_CYCLES=0 instance.
  always @(negedge clk) begin
    if (rst_n && bus_b.out_data_mem) begin
      acks_b++;
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack_b: ack at cycle %0d, none expected", cyc);
      end else begin
        eb = q_b.pop_front();
        chk("ack_cycle_b", cyc, eb.ack_cyc);
        chk("rdata_b", {16'h0, bus_b.data}, {16'h0, eb.data});
      end
    end
  end

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
    ref_data = 16'h0000;
  endtask

  // One transaction, started just after a falling edge with both DUTs idle.
  // After acceptance the inputs are replaced by sa/sd/sw; early drops the
  // request during the wait; hold keeps it high for extra cycles after ack.
  task automatic txn(input bit w, input logic [3:0] a, input logic [15:0] d, input int hold,
                     input bit early, input logic [3:0] sa, input logic [15:0] sd, input bit sw);
    exp_t e;
    int   a0;
    int   b0;
    int   n;
    a0    = acks_a;
    b0    = acks_b;
    req   = 1'b1;
    wr    = w;
    adr   = a;
    wdata = d;
    if (w) begin
      e.data     = ref_data;
      ref_mem[a] = d;
    end else begin
      ref_data = ref_mem[a];
      e.data   = ref_data;
    end
    // Accepted on the next rising edge; ack visible WAIT_CYCLES edges later.
    e.ack_cyc = cyc + 1 + 2;
    q_a.push_back(e);
    e.ack_cyc = cyc + 1;
    q_b.push_back(e);
    step();
    adr   = sa;
    wdata = sd;
    wr    = sw;
    if (early) req = 1'b0;
    n = 0;
    while (!(acks_a > a0 && acks_b > b0) && n < 40) begin
      step();
      n++;
    end
    chk("ack_timeout", n < 40, 1);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        chk("busy_hold_a", bus_a.busy, 1);
        chk("busy_hold_b", bus_b.busy, 1);
        step();
      end
    end
    req = 1'b0;
    if (early || hold == 0) step();
    step();
    chk("idle_a", bus_a.busy, 0);
    chk("idle_b", bus_b.busy, 0);
    chk("data_hold_a", {16'h0, bus_a.data}, {16'h0, ref_data});
    chk("data_hold_b", {16'h0, bus_b.data}, {16'h0, ref_data});
  endtask

  task automatic txn_simple(input bit w, input logic [3:0] a, input logic [15:0] d);
    txn(w, a, d, 1, 1'b0, a, d, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    req   = 1'b0;
    wr    = 1'b0;
    adr   = 4'h0;
    wdata = 16'h0000;
    ref_reset();

    // Outputs during reset.
    #1;
    chk("rst_busy_a", bus_a.busy, 0);
    chk("rst_ack_a", bus_a.out_data_mem, 0);
    chk("rst_data_a", {16'h0, bus_a.data}, 32'h0);
    chk("rst_busy_b", bus_b.busy, 0);
    chk("rst_ack_b", bus_b.out_data_mem, 0);
    chk("rst_data_b", {16'h0, bus_b.data}, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // Read of reset memory, then write/read-back and an untouched neighbour.
    txn_simple(1'b0, 4'h3, 16'h0000);
    txn_simple(1'b1, 4'h5, 16'hBEEF);
    txn_simple(1'b0, 4'h5, 16'h0000);
    txn_simple(1'b0, 4'h6, 16'h0000);

    // Inputs changed while the write is in flight must not leak into it.
    txn(1'b1, 4'h1, 16'h1234, 1, 1'b0, 4'h2, 16'hFFFF, 1'b1);
    txn_simple(1'b0, 4'h1, 16'h0000);
    txn_simple(1'b0, 4'h2, 16'h0000);

    // Request held ten cycles past the ack: still exactly one ack.
    txn(1'b0, 4'h5, 16'h0000, 10, 1'b0, 4'h5, 16'h0000, 1'b0);

    // Request dropped during the wait still completes.
    txn(1'b1, 4'h9, 16'h0F0F, 0, 1'b1, 4'h0, 16'h0000, 1'b0);
    txn_simple(1'b0, 4'h9, 16'h0000);

    // Write then immediately read the same address.
    txn_simple(1'b1, 4'hF, 16'hA5A5);
    txn_simple(1'b0, 4'hF, 16'h0000);

    // Reset between edges during the wait of a write to address 7.
    req   = 1'b1;
    wr    = 1'b1;
    adr   = 4'h7;
    wdata = 16'h7777;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_a", bus_a.busy, 0);
    chk("midrst_ack_a", bus_a.out_data_mem, 0);
    chk("midrst_data_a", {16'h0, bus_a.data}, 32'h0);
    chk("midrst_busy_b", bus_b.busy, 0);
    chk("midrst_ack_b", bus_b.out_data_mem, 0);
    chk("midrst_data_b", {16'h0, bus_b.data}, 32'h0);
    req = 1'b0;
    ref_reset();
    q_a.delete();
    q_b.delete();
    step();
    rst_n = 1'b1;
    // First request right after release; memory must have been cleared.
    txn_simple(1'b0, 4'h7, 16'h0000);
    txn_simple(1'b0, 4'h5, 16'h0000);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
          int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    chk("queue_empty_a", q_a.size(), 0);
    chk("queue_empty_b", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of busy cycles between request acceptance and acknowledge (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_data_mem, input, 1, request from the CPU, level, held high until acknowledged.
REQ-005 The block SHALL have port write_data, input, 1, transaction type: 1 = write, 0 = read.
REQ-006 The block SHALL have port adr, input, 4, word address.
REQ-007 The block SHALL have port data_write, input, 16, write data.
REQ-008 The block SHALL have port data, output, 16, read data, registered.
REQ-009 The block SHALL have port out_data_mem, output, 1, acknowledge, one-cycle pulse.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 Storage SHALL be 16 words x 16 bits, indexed by the captured adr.
REQ-012 The FSM SHALL have states IDLE, BUSY, ACK and RELEASE, with a 4-bit wait counter.
REQ-013 IDLE: when in_data_mem=1 at a rising edge, the FSM SHALL capture adr, write_data and data_write, load counter = WAIT_CYCLES-1, and go to BUSY, or go to ACK if WAIT_CYCLES=0.
REQ-014 IDLE with in_data_mem=0 SHALL remain IDLE with no state change.
REQ-015 BUSY SHALL decrement the counter each edge and go to ACK on the edge where counter=0, so that BUSY lasts exactly WAIT_CYCLES cycles.
REQ-016 On the edge entering ACK, a write SHALL store the captured data_write at the captured adr, and data SHALL remain unchanged.
REQ-017 On the edge entering ACK, a read SHALL load data with mem[captured adr].
REQ-018 out_data_mem SHALL be 1 only in ACK, for exactly one cycle, i.e. in the cycle following edge E0+WAIT_CYCLES, where E0 is the acceptance edge.
REQ-019 ACK SHALL go to RELEASE unconditionally.
REQ-020 RELEASE SHALL stay while in_data_mem=1 and go to IDLE on the first edge where in_data_mem=0, so that a held request is never serviced twice.
REQ-021 Changes on adr, write_data, data_write or in_data_mem after acceptance SHALL NOT affect the transaction in flight; deasserting in_data_mem during BUSY SHALL NOT abort it.
REQ-022 data SHALL hold its last read value indefinitely until the next read completes.
REQ-023 A read of an address written by the immediately preceding transaction SHALL return the newly written value.
REQ-024 Minimum back-to-back spacing SHALL be: acceptance, WAIT_CYCLES busy cycles, ACK, at least one RELEASE cycle with in_data_mem=0, then IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and set the counter to 0, data to 16'h0000, out_data_mem to 0, busy to 0, and all 16 memory words to 16'h0000.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no memory write, and no acknowledge SHALL follow reset release.
REQ-027 After rst_n rises, the first request SHALL be acceptable at the first rising edge where rst_n=1.

Verification
REQ-028 Reset then read with WAIT_CYCLES=2, adr=4'h3 -> data=16'h0000; out_data_mem high one cycle, in the third cycle after acceptance.
REQ-029 Write adr=4'h5, data_write=16'hBEEF, then read adr=4'h5 -> data=16'hBEEF; a read of adr=4'h6 -> 16'h0000.
REQ-030 Hold in_data_mem=1 for 10 cycles after the ack -> exactly one out_data_mem pulse; busy stays 1 until in_data_mem drops, then IDLE on the next edge.
REQ-031 Accept a write adr=4'h1, data_write=16'h1234, then change adr to 4'h2 and data_write to 16'hFFFF during BUSY -> mem[1]=16'h1234, mem[2] unchanged.
REQ-032 Assert rst_n=0 asynchronously between edges during BUSY of a write to adr=4'h7 -> outputs are 0 immediately, no ack, and mem[7] reads 16'h0000 afterwards.
REQ-033 With WAIT_CYCLES=0, read adr=4'hF after writing 16'hA5A5 -> ack in the cycle immediately following acceptance, data=16'hA5A5.
